controle_alarme: RTL and testbench
==================================

# controle_alarme

Downstream consumer of the sequence detector's `alarme` output. It arms and disarms the alarm system, turns a rising edge on `alarme` into a latched trigger, and drives a blinking siren with a minimum on-time. The siren is silenced only by a user acknowledge, and the block keeps a saturating count of trigger events. It sits between the detector and the panel outputs (siren, LEDs, event display).

## Interface

- `BLINK_HALF`, default 4: siren half-period in clock cycles, ≥1.
- `HOLD_MIN`, default 16: minimum cycles in DISPARADO before `ack` is honoured, ≥1.
- `CNT_W`, default 8: width of the event counter.

- `clk`  in  1  single system clock, rising edge.
- `reset`  in  1  asynchronous, active-low; asserting it (0) immediately forces all state and outputs to reset values.
- `armar`  in  1  level; 1 = system armed by user.
- `alarme`  in  1  level from the sequence detector, synchronous to `clk`.
- `ack`  in  1  level; user acknowledge / clear.
- `sirene`  out  1  siren drive, registered.
- `led_armado`  out  1  1 while state is ARMADO, DISPARADO or SILENCIADO, registered.
- `disparado`  out  1  1 while state is DISPARADO or SILENCIADO, registered.
- `eventos`  out  CNT_W  trigger count, saturating, registered.

## Operation

- Edge detect: register `alarme_q` (reset 0). `rise = alarme & ~alarme_q`. This register is updated every cycle in every state.
- States: DESARMADO (reset state), ARMADO, DISPARADO, SILENCIADO.
- DESARMADO:
  - `armar`=1 → ARMADO.
  - Otherwise, `ack`=1 clears `eventos` to 0.
  - `alarme` is ignored.
- ARMADO:
  - `armar`=0 → DESARMADO. This has priority over `rise`.
  - Else `rise`=1 → DISPARADO, with `eventos` incremented (saturates at 2^CNT_W−1).
  - An `alarme` level that is already high when arming does not trigger; it must fall and rise again.
- DISPARADO:
  - `armar` is ignored; only `ack` leaves this state.
  - On entry: `hold_cnt`=0, `blink_cnt`=0, `sirene`=1.
  - Each further cycle: `hold_cnt` increments, saturating at HOLD_MIN.
  - `blink_cnt` increments; when `blink_cnt`==BLINK_HALF−1, `sirene` toggles and `blink_cnt`→0.
  - `ack` is honoured only when `hold_cnt`==HOLD_MIN. Then `alarme`=0 → ARMADO; `alarme`=1 → SILENCIADO.
  - Further `rise` events in DISPARADO do not increment `eventos`.
- SILENCIADO:
  - `sirene`=0.
  - `alarme`=0 → ARMADO.
  - `armar` is ignored.
  - `rise` cannot occur here without `alarme` first falling, which leaves the state.
- Outside DISPARADO, `sirene`=0.
- `led_armado` and `disparado` are registered decodes of the next state.

## Timing

- Reset values: state DESARMADO, `sirene`=0, `led_armado`=0, `disparado`=0, `eventos`=0, all internal counters and `alarme_q` = 0.
- Reset mid-DISPARADO drops the siren immediately (asynchronously), not at the next edge.
- `armar` 0→1 sampled at edge E: `led_armado`=1 after E.
- Trigger latency:
  - `alarme` first sampled high at edge E (in ARMADO) → `sirene`, `disparado`, and incremented `eventos` visible after E.
  - The detector asserts `alarme` one cycle after the third 1 bit, so the siren follows the third bit by two edges.
- Siren pattern: high for BLINK_HALF cycles after entry, then low for BLINK_HALF, repeating.
- Acknowledge window: entry at edge E; the earliest honoured `ack` is sampled at edge E+HOLD_MIN+1. `ack` held from entry therefore leaves at E+HOLD_MIN+1.
- Acknowledge response: `sirene`=0 and state change visible after the honouring edge.
- Simultaneous events:
  - ARMADO with `armar`=0 and `rise`=1: disarm, no count.
  - DESARMADO with `armar`=1 and `ack`=1: arm, `eventos` not cleared.

## Test plan

- Reset and arm: hold `reset`=0 for 3 cycles, release, `armar`=1 at edge 1 → `led_armado`=1 after edge 1, all other outputs 0, `eventos`=0.
- Trigger and blink: armed; `alarme` 0→1 sampled at edge E → `sirene`=1 for edges E..E+3, 0 for E+4..E+7, 1 from E+8; `disparado`=1; `eventos`=1.
- Acknowledge window (HOLD_MIN=16): `ack`=1 held from E+1, `alarme` falls at E+5 → state unchanged through E+16; at E+17 → ARMADO, `sirene`=0, `disparado`=0.
- Silenced path: `alarme` held high, `ack` at E+17 → SILENCIADO (`sirene`=0, `disparado`=1); `alarme`=0 at a later edge → ARMADO.
- Arm-while-high and disarm priority:
  - `alarme`=1 before arming, then `armar`=1 → no trigger.
  - `armar`=0 on the same edge as a rise → DESARMADO, `eventos` unchanged.
- Saturation and clear (CNT_W=2): 5 trigger/ack cycles → `eventos`=3. Then disarm, `ack`=1 → `eventos`=0. Async reset mid-DISPARADO → `sirene`=0 before the next clock edge.

Source files
------------

// File: rtl/controle_alarme.sv
// Alarm controller fed by the sequence detector's alarme output.
// Arms/disarms the system, latches a rising edge on alarme as a trigger,
// blinks the siren with a minimum on-time before acknowledge is accepted,
// and keeps a saturating count of trigger events.
module controle_alarme #(
  parameter int BLINK_HALF = 4,
  parameter int HOLD_MIN   = 16,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             armar,
  input  logic             alarme,
  input  logic             ack,
  output logic             sirene,
  output logic             led_armado,
  output logic             disparado,
  output logic [CNT_W-1:0] eventos
);

  localparam int HoldW  = $clog2(HOLD_MIN + 1);
  localparam int BlinkW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  localparam logic [HoldW-1:0]  HoldMax   = HoldW'(HOLD_MIN);
  localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_HALF - 1);
  localparam logic [CNT_W-1:0]  EvMax     = '1;

  typedef enum logic [1:0] {
    DESARMADO,
    ARMADO,
    DISPARADO,
    SILENCIADO
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic               alarme_q;
  logic [HoldW-1:0]   holdCnt_q;
  logic [BlinkW-1:0]  blinkCnt_q;
  logic               sirene_q;
  logic               ledArmado_q;
  logic               disparado_q;
  logic [CNT_W-1:0]   eventos_q;
  logic               rise;
  logic               holdDone;

  assign rise     = alarme & ~alarme_q;
  assign holdDone = (holdCnt_q == HoldMax);

  assign sirene     = sirene_q;
  assign led_armado = ledArmado_q;
  assign disparado  = disparado_q;
  assign eventos    = eventos_q;

  // Next-state selection; disarm wins over a simultaneous rise, and only a
  // held-long-enough acknowledge can leave the triggered state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      DESARMADO: begin
        if (armar) state_d = ARMADO;
      end
      ARMADO: begin
        if (!armar)    state_d = DESARMADO;
        else if (rise) state_d = DISPARADO;
      end
      DISPARADO: begin
        if (ack && holdDone) state_d = alarme ? SILENCIADO : ARMADO;
      end
      SILENCIADO: begin
        if (!alarme) state_d = ARMADO;
      end
      default: state_d = DESARMADO;
    endcase
  end

  // State register plus all registered outputs, counters and the edge-detect flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= DESARMADO;
      alarme_q    <= 1'b0;
      holdCnt_q   <= '0;
      blinkCnt_q  <= '0;
      sirene_q    <= 1'b0;
      ledArmado_q <= 1'b0;
      disparado_q <= 1'b0;
      eventos_q   <= '0;
    end else begin
      alarme_q    <= alarme;
      state_q     <= state_d;
      ledArmado_q <= (state_d != DESARMADO);
      disparado_q <= (state_d == DISPARADO) || (state_d == SILENCIADO);
      case (state_q)
        DESARMADO: begin
          sirene_q <= 1'b0;
          if (!armar && ack) eventos_q <= '0;
        end
        ARMADO: begin
          if (state_d == DISPARADO) begin
            sirene_q   <= 1'b1;
            holdCnt_q  <= '0;
            blinkCnt_q <= '0;
            if (eventos_q != EvMax) eventos_q <= eventos_q + 1'b1;
          end else begin
            sirene_q <= 1'b0;
          end
        end
        DISPARADO: begin
          if (state_d != DISPARADO) begin
            sirene_q   <= 1'b0;
            holdCnt_q  <= '0;
            blinkCnt_q <= '0;
          end else begin
            if (!holdDone) holdCnt_q <= holdCnt_q + 1'b1;
            if (blinkCnt_q == BlinkLast) begin
              sirene_q   <= ~sirene_q;
              blinkCnt_q <= '0;
            end else begin
              blinkCnt_q <= blinkCnt_q + 1'b1;
            end
          end
        end
        default: begin
          sirene_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_controle_alarme.sv
// Bench for controle_alarme: hand-derived vector table for the main
// arm/trigger/blink/acknowledge flows, plus short sequences for counter
// saturation, clearing and asynchronous reset while the siren is on.
module tb_controle_alarme;

  localparam int BlinkHalf = 4;
  localparam int HoldMin   = 16;
  localparam int CntW      = 2;

  logic            clk;
  logic            reset;
  logic            armar;
  logic            alarme;
  logic            ack;
  logic            sirene;
  logic            ledArmado;
  logic            disparado;
  logic [CntW-1:0] eventos;

  typedef struct {
    logic            armar;
    logic            alarme;
    logic            ack;
    int              reps;
    logic            sir;
    logic            led;
    logic            dis;
    logic [CntW-1:0] ev;
  } vec_t;

  typedef struct {
    logic            sir;
    logic            led;
    logic            dis;
    logic [CntW-1:0] ev;
    string           name;
  } exp_t;

  exp_t scoreboard[$];
  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  controle_alarme #(
    .BLINK_HALF(BlinkHalf),
    .HOLD_MIN  (HoldMin),
    .CNT_W     (CntW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .armar     (armar),
    .alarme    (alarme),
    .ack       (ack),
    .sirene    (sirene),
    .led_armado(ledArmado),
    .disparado (disparado),
    .eventos   (eventos)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mkVec(input logic a, input logic al, input logic ak, input int r,
                                 input logic s, input logic l, input logic d,
                                 input logic [CntW-1:0] e);
    vec_t v;
    v.armar  = a;
    v.alarme = al;
    v.ack    = ak;
    v.reps   = r;
    v.sir    = s;
    v.led    = l;
    v.dis    = d;
    v.ev     = e;
    return v;
  endfunction

  function automatic void pushExpect(input logic s, input logic l, input logic d,
                                     input logic [CntW-1:0] e, input string name);
    exp_t x;
    x.sir  = s;
    x.led  = l;
    x.dis  = d;
    x.ev   = e;
    x.name = name;
    scoreboard.push_back(x);
  endfunction

  task automatic checkOutput();
    exp_t e;
    checks++;
    if (scoreboard.size() == 0) begin
      errors++;
      $display("[TB] FAIL scoreboard-empty: got nothing to compare, required one queued expectation");
      return;
    end
    e = scoreboard.pop_front();
    if ({sirene, ledArmado, disparado, eventos} !== {e.sir, e.led, e.dis, e.ev}) begin
      errors++;
      $display("[TB] FAIL %s: got sirene=%b led_armado=%b disparado=%b eventos=%0d, required sirene=%b led_armado=%b disparado=%b eventos=%0d",
               e.name, sirene, ledArmado, disparado, eventos, e.sir, e.led, e.dis, e.ev);
    end
  endtask

  task automatic applyStimulus(input logic a, input logic al, input logic ak,
                               input logic s, input logic l, input logic d,
                               input logic [CntW-1:0] e, input string name);
    armar  = a;
    alarme = al;
    ack    = ak;
    pushExpect(s, l, d, e, name);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  // One full trigger: rise, then ack held with alarme low until honoured.
  task automatic cycleTrigger(input logic [CntW-1:0] ev, input int idx);
    logic sirExp;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, ev, $sformatf("sat%0d.entry", idx));
    for (int k = 1; k <= HoldMin; k++) begin
      sirExp = (((k / BlinkHalf) % 2) == 0);
      applyStimulus(1'b1, 1'b0, 1'b1, sirExp, 1'b1, 1'b1, ev, $sformatf("sat%0d.hold%0d", idx, k));
    end
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, ev, $sformatf("sat%0d.ack", idx));
  endtask

  // Main test sequence.
  initial begin
    reset  = 1'b0;
    armar  = 1'b0;
    alarme = 1'b0;
    ack    = 1'b0;

    for (int i = 0; i < 3; i++)
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, $sformatf("reset%0d", i));
    reset = 1'b1;

    // Arm, trigger at E, ack from E+1, alarme falls at E+5, honoured at E+17.
    vecs.push_back(mkVec(1, 0, 0, 2, 0, 1, 0, 2'd0));
    vecs.push_back(mkVec(1, 1, 0, 1, 1, 1, 1, 2'd1));
    vecs.push_back(mkVec(1, 1, 1, 3, 1, 1, 1, 2'd1));
    vecs.push_back(mkVec(1, 1, 1, 1, 0, 1, 1, 2'd1));
    vecs.push_back(mkVec(1, 0, 1, 3, 0, 1, 1, 2'd1));
    vecs.push_back(mkVec(1, 0, 1, 4, 1, 1, 1, 2'd1));
    vecs.push_back(mkVec(1, 0, 1, 4, 0, 1, 1, 2'd1));
    vecs.push_back(mkVec(1, 0, 1, 1, 1, 1, 1, 2'd1));
    vecs.push_back(mkVec(1, 0, 1, 1, 0, 1, 0, 2'd1));
    vecs.push_back(mkVec(1, 0, 0, 1, 0, 1, 0, 2'd1));
    // Silenced path with armar dropped while triggered (ignored there).
    vecs.push_back(mkVec(1, 1, 0, 1, 1, 1, 1, 2'd2));
    vecs.push_back(mkVec(0, 1, 0, 3, 1, 1, 1, 2'd2));
    vecs.push_back(mkVec(0, 1, 0, 4, 0, 1, 1, 2'd2));
    vecs.push_back(mkVec(0, 1, 0, 4, 1, 1, 1, 2'd2));
    vecs.push_back(mkVec(0, 1, 0, 4, 0, 1, 1, 2'd2));
    vecs.push_back(mkVec(0, 1, 0, 1, 1, 1, 1, 2'd2));
    vecs.push_back(mkVec(0, 1, 1, 1, 0, 1, 1, 2'd2));
    vecs.push_back(mkVec(0, 1, 0, 2, 0, 1, 1, 2'd2));
    vecs.push_back(mkVec(0, 0, 0, 1, 0, 1, 0, 2'd2));
    vecs.push_back(mkVec(0, 0, 0, 1, 0, 0, 0, 2'd2));
    // Arm while alarme already high, then disarm on the same edge as a rise.
    vecs.push_back(mkVec(0, 1, 0, 1, 0, 0, 0, 2'd2));
    vecs.push_back(mkVec(1, 1, 0, 2, 0, 1, 0, 2'd2));
    vecs.push_back(mkVec(1, 0, 0, 1, 0, 1, 0, 2'd2));
    vecs.push_back(mkVec(0, 1, 0, 1, 0, 0, 0, 2'd2));
    // Arm together with ack keeps the count; then disarm and clear.
    vecs.push_back(mkVec(0, 0, 0, 1, 0, 0, 0, 2'd2));
    vecs.push_back(mkVec(1, 0, 1, 1, 0, 1, 0, 2'd2));
    vecs.push_back(mkVec(0, 0, 0, 1, 0, 0, 0, 2'd2));
    vecs.push_back(mkVec(0, 0, 1, 1, 0, 0, 0, 2'd0));

    for (int i = 0; i < vecs.size(); i++)
      for (int r = 0; r < vecs[i].reps; r++)
        applyStimulus(vecs[i].armar, vecs[i].alarme, vecs[i].ack,
                      vecs[i].sir, vecs[i].led, vecs[i].dis, vecs[i].ev,
                      $sformatf("vec%0d.%0d", i, r));

    // Saturating counter: five triggers from zero end at 3.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, "sat.arm");
    cycleTrigger(2'd1, 1);
    cycleTrigger(2'd2, 2);
    cycleTrigger(2'd3, 3);
    cycleTrigger(2'd3, 4);
    cycleTrigger(2'd3, 5);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, "sat.disarm");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, "sat.clear");

    // Asynchronous reset while the siren is on.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, "async.arm");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'd1, "async.trigger");
    reset = 1'b0;
    #1;
    pushExpect(1'b0, 1'b0, 1'b0, 2'd0, "async.reset");
    checkOutput();
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, "async.rearm");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
